cat_recognizer_apb_sequencer: RTL and testbench
===============================================

# cat_recognizer_apb_sequencer

APB master that runs one complete classification job on `cat_recognizer`. It streams image/weight words from a source port into consecutive recognizer addresses, then writes the start bit. It polls the control register until the recognizer clears that bit, and returns the latched `CatRecOut` with a one-cycle `done` pulse. The block sits between the system-side loader and the recognizer's APB slave port, so the recognizer needs no CPU involvement.

## Interface
- `Amba_Word`, 24, APB data width.
- `Amba_Addr_Depth`, 13, APB address width.
- `Weight_precision`, 5, carried for parameter-list compatibility with `cat_recognizer`; unused internally.
- `Ctrl_Addr`, 0, recognizer control/status register address. Bit0 = start/busy.
- `Data_Base`, 1, address of the first data word.
- `Poll_Gap`, 4, idle cycles before each status read.
- `Timeout_Polls`, 1024, maximum status reads before abort.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: rising-edge clock.
  - `rst` in 1: asynchronous, active-low reset.
- Job control:
  - `job_start` in 1: start request, sampled only in IDLE.
  - `job_len` in `Amba_Addr_Depth`: number of data words, sampled with `job_start`.
- Source stream:
  - `src_valid` in 1: source word available.
  - `src_data` in `Amba_Word`: source word.
  - `src_ready` out 1: word consumed this cycle.
- APB master:
  - `PADDR` out `Amba_Addr_Depth`.
  - `PSEL` out 1.
  - `PENABLE` out 1.
  - `PWRITE` out 1.
  - `PWDATA` out `Amba_Word`.
  - `PRDATA` in `Amba_Word`.
- Recognizer and job status:
  - `CatRecOut` in 1: recognizer classification output.
  - `busy` out 1: high from job acceptance through the `done` cycle.
  - `done` out 1: one-cycle completion pulse.
  - `result` out 1: latched classification, held until the next job is accepted.
  - `timeout_err` out 1: latched abort flag, held until the next job is accepted.

## Operation
- **States:** IDLE, FETCH, W_SETUP, W_ACCESS, S_SETUP, S_ACCESS, GAP, R_SETUP, R_ACCESS, DONE.
- **IDLE:**
  - `job_start`=1 → latch `len = min(job_len, 2^Amba_Addr_Depth - Data_Base)`, set `addr = Data_Base`, clear `result`/`timeout_err`, assert `busy`.
  - Next state is FETCH if `len`>0, else S_SETUP.
- **FETCH:**
  - `src_ready` = `src_valid`; only in this state.
  - On handshake, capture `src_data` into `PWDATA` and go to W_SETUP. Otherwise stay.
- **W_SETUP / W_ACCESS:**
  - Standard APB write to `PADDR=addr`: `PSEL`=1 in both states, `PENABLE`=1 only in ACCESS, `PWRITE`=1.
  - The slave has no PREADY, so every transfer is exactly 2 cycles.
  - After ACCESS: `addr++`, `len--`. Next state is FETCH if `len`>0, else S_SETUP.
- **S_SETUP / S_ACCESS:** APB write of `PWDATA=1` to `Ctrl_Addr`, then go to GAP with poll counter = 0.
- **GAP:** `PSEL`=0 for `Poll_Gap` cycles, then go to R_SETUP.
- **R_SETUP / R_ACCESS:**
  - APB read of `Ctrl_Addr` (`PWRITE`=0); `PRDATA` is sampled at the end of R_ACCESS.
  - Bit0=0: `result` ← `CatRecOut` sampled in that same cycle, then go to DONE.
  - Bit0=1: increment the poll counter. If it reaches `Timeout_Polls`, set `timeout_err`=1, keep `result`=0, go to DONE. Otherwise go to GAP.
- **DONE:** `done`=1 for one cycle, `busy` stays 1 this cycle, then go to IDLE.
- **Idle bus values:** outside SETUP/ACCESS, `PSEL`=`PENABLE`=0. `PADDR`/`PWDATA` hold their last value. `PWRITE` is 0 outside write states.
- **Simultaneous events:**
  - `job_start` while not in IDLE (including DONE) is ignored, not queued.
  - `src_valid` outside FETCH is ignored.
- **Address wrap:** the clamp on `len` guarantees `addr` never wraps past `2^Amba_Addr_Depth - 1`.

## Timing
- **Reset (`rst`=0), any state, immediately:**
  - State → IDLE.
  - `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `src_ready`, `busy`, `done`, `result`, `timeout_err` all = 0.
  - All counters = 0.
  - A transfer in progress is abandoned; the job is not resumed.
- **Outputs:** all registered except `src_ready`, which is combinational from state and `src_valid`.
- **Load throughput:** 3 cycles/word with `src_valid` held high (FETCH, W_SETUP, W_ACCESS).
- **Job latency with no stalls:**
  - `job_start` → first `PSEL`: 2 cycles.
  - Minimum job: `1 + 3·len + 2 + k·(Poll_Gap+2) + 1` cycles for k polls.

## Test plan
- **Reset:** `rst`=0 mid-W_ACCESS → same cycle all outputs 0. After release with no `job_start`, the bus stays idle.
- **3-word job:**
  - Stimulus: `job_len`=3, words 0x000AAA/0x000BBB/0x000CCC, `src_valid` always 1.
  - Writes: addr 1,2,3 with those data, each PSEL/PENABLE 2-cycle pattern.
  - Start: write 0x000001 to addr 0.
  - Polls: `PRDATA` bit0=1 twice, then 0 with `CatRecOut`=1.
  - Expected: `done` pulse, `result`=1, `timeout_err`=0. Total 1+9+2+3·6+1=31 cycles.
- **Source stall:** `src_valid` low 5 cycles before word 2 → FSM holds FETCH, `PSEL`=0, no duplicated or skipped address.
- **Zero length:** `job_len`=0 → first transfer is the start write to addr 0. No `src_ready` pulse.
- **Timeout:** `Timeout_Polls`=4, bit0 stuck 1 → exactly 4 reads, then `done` with `timeout_err`=1, `result`=0.
- **Clamp and ignore:**
  - `job_len`=8191 → last write addr 8191, no wrap.
  - `job_start` pulsed while busy → no second job.

Source files
------------

// File: rtl/cat_recognizer_apb_sequencer_if.sv
// APB bus between the job sequencer (master) and the cat_recognizer slave port.
// The recognizer has no PREADY, so every transfer is a fixed two-cycle SETUP/ACCESS pair.
interface cat_recognizer_apb_sequencer_if #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13
);
  logic [Amba_Addr_Depth-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [Amba_Word-1:0]       PWDATA;
  logic [Amba_Word-1:0]       PRDATA;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA
  );
endinterface

// File: rtl/cat_recognizer_apb_sequencer.sv
// Runs one classification job on cat_recognizer: streams source words into consecutive
// data addresses, writes the start bit, polls the control register until the recognizer
// clears it (or the poll budget runs out) and reports the latched result with a done pulse.
module cat_recognizer_apb_sequencer #(
  parameter int Amba_Word        = 24,
  parameter int Amba_Addr_Depth  = 13,
  parameter int Weight_precision = 5,
  parameter int Ctrl_Addr        = 0,
  parameter int Data_Base        = 1,
  parameter int Poll_Gap         = 4,
  parameter int Timeout_Polls    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_start,
  input  logic [Amba_Addr_Depth-1:0] job_len,
  input  logic                       src_valid,
  input  logic [Amba_Word-1:0]       src_data,
  output logic                       src_ready,
  cat_recognizer_apb_sequencer_if.master apb,
  input  logic                       CatRecOut,
  output logic                       busy,
  output logic                       done,
  output logic                       result,
  output logic                       timeout_err
);

  // Length and address carry one extra bit so the clamp value and the post-increment
  // address after the very last data word are representable.
  localparam int LW = Amba_Addr_Depth + 1;
  localparam logic [LW-1:0] MaxLen   = LW'((2 ** Amba_Addr_Depth) - Data_Base);
  localparam logic [LW-1:0] DataBase = LW'(Data_Base);
  localparam logic [Amba_Addr_Depth-1:0] CtrlAddr = Amba_Addr_Depth'(Ctrl_Addr);
  localparam int PollW = $clog2(Timeout_Polls + 1);
  localparam logic [PollW-1:0] PollLast = PollW'(Timeout_Polls - 1);
  localparam int GapW = (Poll_Gap > 1) ? $clog2(Poll_Gap) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((Poll_Gap > 0) ? Poll_Gap - 1 : 0);
  // Kept only so the parameter list matches cat_recognizer.
  localparam int unused_weight_precision = Weight_precision;

  typedef enum logic [3:0] {
    IDLE, FETCH, W_SETUP, W_ACCESS, S_SETUP, S_ACCESS, GAP, R_SETUP, R_ACCESS, DONE
  } state_t;

  state_t state_reg, state_next;
  logic [LW-1:0] addr_reg, addr_next;
  logic [LW-1:0] len_reg, len_next;
  logic [PollW-1:0] poll_reg, poll_next;
  logic [GapW-1:0] gap_reg, gap_next;
  logic result_reg, result_next;
  logic timeout_reg, timeout_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic psel_reg, psel_next;
  logic penable_reg, penable_next;
  logic pwrite_reg, pwrite_next;
  logic [Amba_Addr_Depth-1:0] paddr_reg, paddr_next;
  logic [Amba_Word-1:0] pwdata_reg, pwdata_next;
  logic [LW-1:0] job_len_ext;

  // Only the busy bit of the status register matters.
  logic unused_prdata;
  assign unused_prdata = ^apb.PRDATA[Amba_Word-1:1];

  assign job_len_ext = {1'b0, job_len};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next state, datapath updates, and bus values for the coming cycle (decoded from state_next
  // so every bus output leaves a flop).
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    len_next     = len_reg;
    poll_next    = poll_reg;
    gap_next     = gap_reg;
    result_next  = result_reg;
    timeout_next = timeout_reg;
    paddr_next   = paddr_reg;
    pwdata_next  = pwdata_reg;
    src_ready    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (job_start) begin
          len_next     = (job_len_ext > MaxLen) ? MaxLen : job_len_ext;
          addr_next    = DataBase;
          result_next  = 1'b0;
          timeout_next = 1'b0;
          state_next   = (len_next != '0) ? FETCH : S_SETUP;
        end
      end
      FETCH: begin
        src_ready = src_valid;
        if (src_valid) begin
          pwdata_next = src_data;
          state_next  = W_SETUP;
        end
      end
      W_SETUP: state_next = W_ACCESS;
      W_ACCESS: begin
        addr_next  = addr_reg + 1'b1;
        len_next   = len_reg - 1'b1;
        state_next = (len_next != '0) ? FETCH : S_SETUP;
      end
      S_SETUP: state_next = S_ACCESS;
      S_ACCESS: begin
        poll_next  = '0;
        gap_next   = '0;
        state_next = (Poll_Gap == 0) ? R_SETUP : GAP;
      end
      GAP: begin
        if (gap_reg == GapLast) begin
          gap_next   = '0;
          state_next = R_SETUP;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      R_SETUP: state_next = R_ACCESS;
      R_ACCESS: begin
        if (!apb.PRDATA[0]) begin
          result_next = CatRecOut;
          state_next  = DONE;
        end else if (poll_reg == PollLast) begin
          timeout_next = 1'b1;
          result_next  = 1'b0;
          state_next   = DONE;
        end else begin
          poll_next  = poll_reg + 1'b1;
          gap_next   = '0;
          state_next = (Poll_Gap == 0) ? R_SETUP : GAP;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    psel_next    = state_next inside {W_SETUP, W_ACCESS, S_SETUP, S_ACCESS, R_SETUP, R_ACCESS};
    penable_next = state_next inside {W_ACCESS, S_ACCESS, R_ACCESS};
    pwrite_next  = state_next inside {W_SETUP, W_ACCESS, S_SETUP, S_ACCESS};
    if (state_next == W_SETUP) paddr_next = addr_reg[Amba_Addr_Depth-1:0];
    if (state_next == S_SETUP || state_next == R_SETUP) paddr_next = CtrlAddr;
    if (state_next == S_SETUP) pwdata_next = Amba_Word'(1);
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg    <= '0;
      len_reg     <= '0;
      poll_reg    <= '0;
      gap_reg     <= '0;
      result_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
    end else begin
      addr_reg    <= addr_next;
      len_reg     <= len_next;
      poll_reg    <= poll_next;
      gap_reg     <= gap_next;
      result_reg  <= result_next;
      timeout_reg <= timeout_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      pwrite_reg  <= pwrite_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
    end
  end

  assign apb.PSEL    = psel_reg;
  assign apb.PENABLE = penable_reg;
  assign apb.PWRITE  = pwrite_reg;
  assign apb.PADDR   = paddr_reg;
  assign apb.PWDATA  = pwdata_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign result      = result_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_cat_recognizer_apb_sequencer.sv
// Bench for cat_recognizer_apb_sequencer: an APB slave/source model records every transfer,
// and each job is compared against a transfer list and timing built from the job description.
module tb_cat_recognizer_apb_sequencer;
  localparam int AW = 24;
  localparam int AD = 13;
  localparam int PG = 4;
  localparam int TP = 4;
  localparam int DB = 1;
  localparam int MAXLEN = (1 << AD) - DB;

  typedef struct packed {
    logic          wr;
    logic [AD-1:0] addr;
    logic [AW-1:0] data;
  } xfer_t;

  typedef struct {
    int len; int bsy; bit catv; int st_idx; int st_len; bit poke;
    bit exp_res; bit exp_to; int exp_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic job_start;
  logic [AD-1:0] job_len;
  logic src_valid;
  logic [AW-1:0] src_data;
  logic src_ready;
  logic cat;
  logic busy, done, result, timeout_err;

  int checks = 0;
  int failures = 0;

  // Slave/source model state shared between the monitor and the job driver.
  xfer_t got_q[$];
  logic [AW-1:0] word_q[$];
  int prot_err, rdy_err, reads_seen, busy_polls, words_sent;
  bit hs_pending, cat_val, prev_setup;
  xfer_t prev_x;

  always #5 clk = ~clk;

  cat_recognizer_apb_sequencer_if #(.Amba_Word(AW), .Amba_Addr_Depth(AD)) apb ();

  cat_recognizer_apb_sequencer #(
    .Amba_Word(AW), .Amba_Addr_Depth(AD), .Weight_precision(5), .Ctrl_Addr(0),
    .Data_Base(DB), .Poll_Gap(PG), .Timeout_Polls(TP)
  ) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_len(job_len),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .apb(apb), .CatRecOut(cat), .busy(busy), .done(done), .result(result),
    .timeout_err(timeout_err)
  );

  task automatic check(input string what, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", what, act, exp);
    end
  endtask

  // Monitor + APB slave: samples mid-cycle, logs completed transfers, and drives PRDATA and
  // CatRecOut so that only the values present during R_ACCESS give the intended answer.
  initial begin
    xfer_t cur;
    logic [31:0] rnd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_setup = 1'b0;
      end else begin
        if (apb.PENABLE && !apb.PSEL) prot_err++;
        if (apb.PWRITE && !apb.PSEL) prot_err++;
        if (src_ready && !src_valid) rdy_err++;
        if (src_ready && src_valid) hs_pending = 1'b1;
        cur = {apb.PWRITE, apb.PADDR, apb.PWDATA};
        if (apb.PSEL && !apb.PENABLE) begin
          if (prev_setup) prot_err++;
          prev_setup = 1'b1;
          prev_x = cur;
        end else if (apb.PSEL) begin
          if (!prev_setup || cur != prev_x) prot_err++;
          prev_setup = 1'b0;
          if (apb.PWRITE) got_q.push_back(cur);
          else got_q.push_back({1'b0, apb.PADDR, {AW{1'b0}}});
        end else begin
          if (prev_setup) prot_err++;
          prev_setup = 1'b0;
        end
        rnd = $urandom;
        if (apb.PSEL && apb.PENABLE && !apb.PWRITE) begin
          apb.PRDATA = {rnd[AW-1:1], (reads_seen < busy_polls)};
          reads_seen++;
          cat = cat_val;
        end else begin
          apb.PRDATA = {rnd[AW-1:1], 1'b1};
          cat = ~cat_val;
        end
      end
    end
  end

  // Job-level reference: k status reads, result only on a clean finish, fixed-cost phases.
  function automatic void model(input int len, input int bsy, input bit catv, input int st_idx,
                                input int st_len, output bit r, output bit t, output int cyc);
    int l, k, extra;
    l = (len > MAXLEN) ? MAXLEN : len;
    k = (bsy + 1 < TP) ? bsy + 1 : TP;
    t = (bsy >= TP);
    r = t ? 1'b0 : catv;
    extra = (st_idx >= 1 && st_idx < l && st_len > 2) ? st_len - 2 : 0;
    cyc = 1 + 3 * l + 2 + k * (PG + 2) + 1 + extra;
  endfunction

  task automatic run_and_check(input string name, input int len, input int bsy, input bit catv,
                               input int st_idx, input int st_len, input bit poke,
                               input bit exp_res, input bit exp_to, input int exp_cycles);
    xfer_t exp_q[$];
    int l, k, cycles, budget, mism, stall_left, n;
    bit got_done, res_d, to_d, busy_d;
    l = (len > MAXLEN) ? MAXLEN : len;
    k = (bsy + 1 < TP) ? bsy + 1 : TP;
    @(posedge clk); #1;
    word_q.delete();
    for (int i = 0; i < l; i++) word_q.push_back(AW'($urandom));
    for (int i = 0; i < l; i++) exp_q.push_back({1'b1, AD'(DB + i), word_q[i]});
    exp_q.push_back({1'b1, AD'(0), AW'(1)});
    for (int j = 0; j < k; j++) exp_q.push_back({1'b0, AD'(0), AW'(0)});
    got_q.delete();
    prot_err = 0; rdy_err = 0; reads_seen = 0; busy_polls = bsy; cat_val = catv;
    hs_pending = 1'b0; words_sent = 0; stall_left = 0;
    src_valid = 1'b1;
    src_data = (l > 0) ? word_q[0] : AW'($urandom);
    job_len = AD'(len);
    job_start = 1'b1;
    cycles = 0; got_done = 1'b0; res_d = 1'b0; to_d = 1'b0; busy_d = 1'b0;
    budget = exp_cycles * 2 + 100;
    while (!got_done && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      job_start = poke && ($urandom_range(0, 2) == 0);
      job_len = AD'($urandom);
      if (hs_pending) begin
        hs_pending = 1'b0;
        words_sent++;
        stall_left = (words_sent == st_idx) ? st_len : 0;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      src_valid = (stall_left == 0);
      src_data = (words_sent < l) ? word_q[words_sent] : AW'($urandom);
      if (done) begin
        got_done = 1'b1; res_d = result; to_d = timeout_err; busy_d = busy;
      end
    end
    check({name, ".done_seen"}, got_done, 1);
    check({name, ".cycles"}, cycles + 1, exp_cycles);
    check({name, ".result"}, res_d, exp_res);
    check({name, ".timeout_err"}, to_d, exp_to);
    check({name, ".busy_in_done"}, busy_d, 1);
    check({name, ".src_handshakes"}, words_sent, l);
    check({name, ".xfer_count"}, got_q.size(), exp_q.size());
    mism = -1;
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n && mism < 0; i++)
      if (i >= got_q.size() || i >= exp_q.size() || got_q[i] != exp_q[i]) mism = i;
    check({name, ".xfer_first_diff_index"}, mism, -1);
    check({name, ".apb_protocol_errors"}, prot_err, 0);
    check({name, ".src_ready_without_valid"}, rdy_err, 0);
    @(posedge clk); #1;
    job_start = 1'b0;
    check({name, ".idle_after_done_busy_done"}, {busy, done}, 0);
    check({name, ".result_held"}, result, exp_res);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".ctrl_bits"},
          {apb.PSEL, apb.PENABLE, apb.PWRITE, src_ready, busy, done, result, timeout_err}, 0);
    check({name, ".PADDR"}, apb.PADDR, 0);
    check({name, ".PWDATA"}, apb.PWDATA, 0);
  endtask

  initial begin
    vec_t vecs[6];
    bit r, t, found;
    int cyc, cnt, l, si;
    rst = 1'b0; job_start = 1'b0; job_len = '0; src_valid = 1'b1; src_data = '0;
    cat = 1'b0; apb.PRDATA = '0;

    //        len bsy cat st_idx st_len poke res to cycles
    vecs[0] = '{3, 2, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 31};  // 3-word job, 3 polls
    vecs[1] = '{0, 0, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 10};  // zero length
    vecs[2] = '{2, 9, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1, 34};  // stuck busy -> timeout
    vecs[3] = '{1, 0, 1'b0, -1, 0, 1'b1, 1'b0, 1'b0, 13};  // job_start pokes while busy
    vecs[4] = '{3, 1, 1'b1, 1, 5, 1'b0, 1'b1, 1'b0, 28};   // 5-cycle source stall
    vecs[5] = '{2, 3, 1'b1, -1, 0, 1'b1, 1'b1, 1'b0, 34};  // clears on the last allowed poll

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_initial");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].len, vecs[i].bsy, vecs[i].catv,
                    vecs[i].st_idx, vecs[i].st_len, vecs[i].poke, vecs[i].exp_res,
                    vecs[i].exp_to, vecs[i].exp_cycles);

    // Reset in the middle of a data write, after a job that left result=1.
    @(posedge clk); #1;
    src_valid = 1'b1; src_data = 24'h123456; job_len = AD'(3); job_start = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (apb.PSEL && apb.PENABLE && apb.PWRITE) found = 1'b1;
    end
    check("rst_mid.reached_w_access", found, 1);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (apb.PSEL || busy || src_ready) cnt++;
    end
    check("rst_mid.bus_idle_after_release", cnt, 0);

    // Longest possible job: last data word lands on the top address.
    model(MAXLEN, 0, 1'b1, -1, 0, r, t, cyc);
    run_and_check("clamp", MAXLEN, 0, 1'b1, -1, 0, 1'b0, r, t, cyc);
    check("clamp.last_write_addr", (got_q.size() > MAXLEN - 1) ? got_q[MAXLEN-1].addr : -1, MAXLEN);

    for (int n = 0; n < 12; n++) begin
      bit catv, poke;
      int len, bsy, stl;
      len = $urandom_range(0, 8);
      bsy = $urandom_range(0, 6);
      catv = 1'($urandom_range(0, 1));
      poke = 1'($urandom_range(0, 1));
      stl = $urandom_range(0, 7);
      l = len;
      si = (l >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, l - 1) : -1;
      model(len, bsy, catv, si, stl, r, t, cyc);
      run_and_check($sformatf("rnd%0d", n), len, bsy, catv, si, stl, poke, r, t, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
